// File: rtl/levenshtein_pm_generator_if.sv
// Stream bundle between the dictionary/search-word sources, the pm generator and the distance stage.
// The master drives the inputs of both source streams; the slave (the generator) drives the pm stream.
interface levenshtein_pm_generator_if #(
  parameter int BITVECTOR_WIDTH = 8,
  parameter int CHAR_WIDTH      = 8
);
  logic                       s_word_tvalid;
  logic                       s_word_tready;
  logic [CHAR_WIDTH-1:0]      s_word_tdata;
  logic                       s_word_tlast;

  logic                       s_axis_tvalid;
  logic                       s_axis_tready;
  logic [CHAR_WIDTH-1:0]      s_axis_tdata;
  logic                       s_axis_tlast;
  logic                       s_axis_tuser;

  logic                       m_axis_tvalid;
  logic [BITVECTOR_WIDTH-1:0] m_axis_tdata;
  logic                       m_axis_tuser;
  logic                       m_axis_tlast;

  modport master (
    output s_word_tvalid, s_word_tdata, s_word_tlast,
    input  s_word_tready,
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );

  modport slave (
    input  s_word_tvalid, s_word_tdata, s_word_tlast,
    output s_word_tready,
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, s_axis_tuser,
    output s_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
  );
endinterface

// File: rtl/levenshtein_pm_generator.sv
// Stores a search word and converts a dictionary character stream into pattern-match vectors,
// framing every dictionary word with tuser beats for the downstream distance stage.
//
// state  | meaning
// IDLE   | no search word stored yet
// LOAD   | receiving search word characters
// LOADED | search word stored, waiting for a new word or a dictionary pass
// PRIME  | emit the initial tuser beat of a pass
// STREAM | one pm beat per accepted dictionary character
// TERM   | emit the terminating tuser beat of a dictionary word
module levenshtein_pm_generator #(
  parameter int BITVECTOR_WIDTH = 8,
  parameter int DISTANCE_WIDTH  = 8,
  parameter int CHAR_WIDTH      = 8
) (
  input  logic                       aclk,
  input  logic                       areset,
  levenshtein_pm_generator_if.slave  bus,
  output logic [DISTANCE_WIDTH-1:0]  word_size,
  output logic [BITVECTOR_WIDTH-1:0] mask,
  output logic                       word_overflow
);

  localparam logic [DISTANCE_WIDTH-1:0] BVW_D = DISTANCE_WIDTH'(BITVECTOR_WIDTH);

  typedef enum logic [2:0] {
    IDLE, LOAD, LOADED, PRIME, STREAM, TERM
  } state_t;

  state_t                      state_q, state_d;
  logic [CHAR_WIDTH-1:0]       word_q [BITVECTOR_WIDTH];
  logic [CHAR_WIDTH-1:0]       word_d [BITVECTOR_WIDTH];
  logic [DISTANCE_WIDTH-1:0]   count_q, count_d;
  logic [BITVECTOR_WIDTH-1:0]  mask_q, mask_d;
  logic                        ovf_q, ovf_d;
  logic                        pass_end_q, pass_end_d;
  logic                        m_valid_q, m_valid_d;
  logic [BITVECTOR_WIDTH-1:0]  m_data_q, m_data_d;
  logic                        m_user_q, m_user_d;
  logic                        m_last_q, m_last_d;
  logic                        word_rdy, char_rdy, word_acc, char_acc;

  assign word_rdy = (state_q == IDLE) || (state_q == LOAD) || (state_q == LOADED);
  assign char_rdy = (state_q == STREAM);
  assign word_acc = word_rdy && bus.s_word_tvalid;
  assign char_acc = char_rdy && bus.s_axis_tvalid;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    count_d    = count_q;
    mask_d     = mask_q;
    ovf_d      = ovf_q;
    pass_end_d = pass_end_q;
    m_valid_d  = 1'b0;
    m_data_d   = '0;
    m_user_d   = 1'b0;
    m_last_d   = 1'b0;

    case (state_q)
      IDLE, LOADED: begin
        if (word_acc) begin
          // The accepting beat is already character 0 of the new word.
          word_d[0] = bus.s_word_tdata;
          count_d   = DISTANCE_WIDTH'(1);
          mask_d    = BITVECTOR_WIDTH'(1);
          ovf_d     = 1'b0;
          state_d   = bus.s_word_tlast ? LOADED : LOAD;
        end else if ((state_q == LOADED) && bus.s_axis_tvalid) begin
          state_d = PRIME;
        end
      end
      LOAD: begin
        if (word_acc) begin
          if (count_q < BVW_D) begin
            for (int j = 0; j < BITVECTOR_WIDTH; j++) begin
              if (count_q == DISTANCE_WIDTH'(j)) word_d[j] = bus.s_word_tdata;
            end
            mask_d  = BITVECTOR_WIDTH'(1) << count_q;
            count_d = count_q + DISTANCE_WIDTH'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (bus.s_word_tlast) state_d = LOADED;
        end
      end
      PRIME: begin
        m_valid_d = 1'b1;
        m_user_d  = 1'b1;
        state_d   = STREAM;
      end
      STREAM: begin
        if (char_acc) begin
          m_valid_d = 1'b1;
          for (int j = 0; j < BITVECTOR_WIDTH; j++) begin
            m_data_d[j] = (word_q[j] == bus.s_axis_tdata) && (DISTANCE_WIDTH'(j) < count_q);
          end
          if (bus.s_axis_tlast) begin
            pass_end_d = bus.s_axis_tuser;
            state_d    = TERM;
          end
        end
      end
      TERM: begin
        m_valid_d = 1'b1;
        m_user_d  = 1'b1;
        m_last_d  = pass_end_q;
        state_d   = pass_end_q ? LOADED : STREAM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      mask_q     <= '0;
      ovf_q      <= 1'b0;
      pass_end_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_user_q   <= 1'b0;
      m_last_q   <= 1'b0;
      for (int j = 0; j < BITVECTOR_WIDTH; j++) word_q[j] <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mask_q     <= mask_d;
      ovf_q      <= ovf_d;
      pass_end_q <= pass_end_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_user_q   <= m_user_d;
      m_last_q   <= m_last_d;
      for (int j = 0; j < BITVECTOR_WIDTH; j++) word_q[j] <= word_d[j];
    end
  end

  assign bus.s_word_tready = word_rdy;
  assign bus.s_axis_tready = char_rdy;
  assign bus.m_axis_tvalid = m_valid_q;
  assign bus.m_axis_tdata  = m_data_q;
  assign bus.m_axis_tuser  = m_user_q;
  assign bus.m_axis_tlast  = m_last_q;
  assign word_size         = count_q;
  assign mask              = mask_q;
  assign word_overflow     = ovf_q;

endmodule

// File: tb/tb_levenshtein_pm_generator.sv
// Directed bench for the pm generator: word loading, pm vectors, word framing, overflow and reset.
module tb_levenshtein_pm_generator;

  localparam int BVW   = 8;
  localparam int DISTW = 8;
  localparam int CHW   = 8;

  logic             aclk = 1'b0;
  logic             areset;
  logic [DISTW-1:0] word_size;
  logic [BVW-1:0]   mask;
  logic             word_overflow;

  int n_checks = 0;
  int n_errors = 0;

  levenshtein_pm_generator_if #(.BITVECTOR_WIDTH(BVW), .CHAR_WIDTH(CHW)) bus ();

  levenshtein_pm_generator #(
    .BITVECTOR_WIDTH(BVW), .DISTANCE_WIDTH(DISTW), .CHAR_WIDTH(CHW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .bus           (bus),
    .word_size     (word_size),
    .mask          (mask),
    .word_overflow (word_overflow)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic load_word(input string s);
    for (int i = 0; i < s.len(); i++) begin
      bus.s_word_tvalid = 1'b1;
      bus.s_word_tdata  = s[i];
      bus.s_word_tlast  = (i == s.len() - 1);
      chk("s_word_tready", bus.s_word_tready, 1);
      tick();
    end
    bus.s_word_tvalid = 1'b0;
    bus.s_word_tlast  = 1'b0;
  endtask

  task automatic start_pass(input logic [7:0] c);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = c;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;
    tick();
    chk("prime_tready", bus.s_axis_tready, 0);
    chk("prime_novalid", bus.m_axis_tvalid, 0);
    tick();
    chk("init_valid", bus.m_axis_tvalid, 1);
    chk("init_user", bus.m_axis_tuser, 1);
    chk("init_data", bus.m_axis_tdata, 0);
    chk("init_last", bus.m_axis_tlast, 0);
  endtask

  // exp holds the expected pm byte for character i in bits [8*i +: 8].
  task automatic dict_word(input string s, input logic pass_last, input logic [63:0] exp);
    for (int i = 0; i < s.len(); i++) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = s[i];
      bus.s_axis_tlast  = (i == s.len() - 1);
      bus.s_axis_tuser  = pass_last && (i == s.len() - 1);
      chk("stream_tready", bus.s_axis_tready, 1);
      tick();
      chk("pm_valid", bus.m_axis_tvalid, 1);
      chk("pm_user", bus.m_axis_tuser, 0);
      chk("pm_last", bus.m_axis_tlast, 0);
      chk("pm_data", bus.m_axis_tdata, exp[8*i +: 8]);
    end
    bus.s_axis_tlast = 1'b0;
    bus.s_axis_tuser = 1'b0;
    if (pass_last) bus.s_axis_tvalid = 1'b0;
    chk("term_tready", bus.s_axis_tready, 0);
    tick();
    chk("term_valid", bus.m_axis_tvalid, 1);
    chk("term_user", bus.m_axis_tuser, 1);
    chk("term_data", bus.m_axis_tdata, 0);
    chk("term_last", bus.m_axis_tlast, pass_last);
  endtask

  initial begin
    areset            = 1'b1;
    bus.s_word_tvalid = 1'b0;
    bus.s_word_tdata  = '0;
    bus.s_word_tlast  = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tuser  = 1'b0;
    tick();
    tick();
    chk("rst_m_valid", bus.m_axis_tvalid, 0);
    chk("rst_word_size", word_size, 0);
    chk("rst_mask", mask, 0);
    chk("rst_overflow", word_overflow, 0);
    chk("rst_s_axis_tready", bus.s_axis_tready, 0);
    chk("rst_s_word_tready", bus.s_word_tready, 1);
    areset = 1'b0;
    tick();

    // search word "cat", then dictionary word "act" as a whole pass
    load_word("cat");
    chk("cat_word_size", word_size, 3);
    chk("cat_mask", mask, 8'h04);
    chk("cat_overflow", word_overflow, 0);
    chk("cat_s_axis_tready", bus.s_axis_tready, 0);
    start_pass("a");
    dict_word("act", 1'b1, 64'h04_01_02);
    tick();
    chk("act_idle_valid", bus.m_axis_tvalid, 0);
    chk("act_loaded_wready", bus.s_word_tready, 1);

    // repeated characters in the search word
    load_word("aaba");
    chk("aaba_word_size", word_size, 4);
    chk("aaba_mask", mask, 8'h08);
    start_pass("a");
    dict_word("az", 1'b1, 64'h00_0B);
    tick();

    // overflow: 10 characters into an 8-wide store, then a reload clears the flag
    load_word("abcdefghij");
    chk("ovf_word_size", word_size, 8);
    chk("ovf_mask", mask, 8'h80);
    chk("ovf_flag", word_overflow, 1);
    load_word("cat");
    chk("reload_word_size", word_size, 3);
    chk("reload_overflow", word_overflow, 0);

    // two dictionary words back to back with tvalid held high
    load_word("at");
    start_pass("a");
    dict_word("at", 1'b0, 64'h02_01);
    dict_word("to", 1'b1, 64'h00_02);
    tick();
    chk("to_idle_valid", bus.m_axis_tvalid, 0);

    // search word load wins over a pending dictionary character
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = "q";
    load_word("z");
    chk("prio_word_size", word_size, 1);
    chk("prio_mask", mask, 8'h01);
    chk("prio_s_axis_tready", bus.s_axis_tready, 0);

    // reset in the middle of a pass
    start_pass("x");
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = "z";
    areset = 1'b1;
    tick();
    chk("mid_rst_m_valid", bus.m_axis_tvalid, 0);
    chk("mid_rst_word_size", word_size, 0);
    chk("mid_rst_mask", mask, 0);
    chk("mid_rst_s_axis_tready", bus.s_axis_tready, 0);
    chk("mid_rst_s_word_tready", bus.s_word_tready, 1);
    areset            = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    tick();
    chk("post_rst_s_axis_tready", bus.s_axis_tready, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
